// File: rtl/vm1_mem_bridge.sv
// Q-BUS slave bridge: turns each 1801VM1 data phase into one req/ack memory transaction,
// returns read data and paces bus_rply with a minimum wait-state count.
module vm1_mem_bridge #(
  parameter logic [15:0] IO_BASE     = 16'o177000,
  parameter logic [15:0] ROM_BASE    = 16'o100000,
  parameter int unsigned WAIT_STATES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_dout,
  input  logic        bus_sync,
  input  logic        bus_din_stb,
  input  logic        bus_dout_stb,
  input  logic [1:0]  bus_wtbt,
  output logic [15:0] bus_din,
  output logic        bus_rply,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, WR_SKIP, REPLY, DRAIN} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic        din_stb_q, dout_stb_q;
  logic [3:0]  wait_q, wait_d;
  logic        rply_q, rply_d;
  logic [15:0] din_q, din_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_be_q, mem_be_d;

  logic rd_rise, wr_rise, mapped, accept_rd, accept_wr, active_stb;

  assign rd_rise   = bus_din_stb & ~din_stb_q;
  assign wr_rise   = bus_dout_stb & ~dout_stb_q;
  assign mapped    = bus_sync && (bus_addr < IO_BASE);
  assign accept_rd = (state_q == IDLE) && mapped && rd_rise;
  // A simultaneous read and write edge resolves to the read.
  assign accept_wr = (state_q == IDLE) && mapped && wr_rise && !rd_rise;
  // mem_we is registered for every accepted write, including ROM writes that skip memory.
  assign active_stb = mem_we_q ? bus_dout_stb : bus_din_stb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_rd)      state_d = RD_REQ;
        else if (accept_wr) state_d = (bus_addr >= ROM_BASE) ? WR_SKIP : WR_REQ;
      end
      RD_REQ, WR_REQ: begin
        // An ack coinciding with the abort completes the request, so nothing is left to drain.
        if (mem_ack)        state_d = bus_sync ? REPLY : IDLE;
        else if (!bus_sync) state_d = DRAIN;
      end
      WR_SKIP: state_d = REPLY;
      REPLY:   if (!active_stb || !bus_sync) state_d = IDLE;
      DRAIN:   if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_d      = (wait_q != 4'd0) ? wait_q - 4'd1 : 4'd0;
    rply_d      = 1'b0;
    din_d       = din_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (accept_rd) begin
      wait_d     = WAIT_INIT;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = bus_addr[15:1];
      mem_be_d   = 2'b11;
    end else if (accept_wr) begin
      wait_d      = WAIT_INIT;
      mem_req_d   = (bus_addr < ROM_BASE);
      mem_we_d    = 1'b1;
      mem_addr_d  = bus_addr[15:1];
      mem_wdata_d = bus_dout;
      mem_be_d    = bus_wtbt;
    end
    if (mem_req_q && mem_ack) mem_req_d = 1'b0;
    if ((state_q == RD_REQ) && mem_ack && bus_sync) din_d = mem_rdata;
    // Looking at wait_d lets the reply land exactly WAIT_STATES clocks after acceptance.
    if ((state_q == REPLY) && active_stb && bus_sync && (wait_d == 4'd0)) rply_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_stb_q   <= 1'b0;
      dout_stb_q  <= 1'b0;
      wait_q      <= 4'd0;
      rply_q      <= 1'b0;
      din_q       <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 15'd0;
      mem_wdata_q <= 16'h0000;
      mem_be_q    <= 2'b00;
    end else begin
      din_stb_q   <= bus_din_stb;
      dout_stb_q  <= bus_dout_stb;
      wait_q      <= wait_d;
      rply_q      <= rply_d;
      din_q       <= din_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign bus_din   = din_q;
  assign bus_rply  = rply_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_vm1_mem_bridge.sv
// Directed bench for vm1_mem_bridge (default parameters, WAIT_STATES=3): a vector table of
// single data phases plus hand sequences for RMW, abort, dual strobes, sync loss and reset.
module tb_vm1_mem_bridge;

  logic        clk;
  logic        reset_n;
  logic [15:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_sync;
  logic        bus_din_stb;
  logic        bus_dout_stb;
  logic [1:0]  bus_wtbt;
  logic [15:0] bus_din;
  logic        bus_rply;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  vm1_mem_bridge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus_addr     (bus_addr),
    .bus_dout     (bus_dout),
    .bus_sync     (bus_sync),
    .bus_din_stb  (bus_din_stb),
    .bus_dout_stb (bus_dout_stb),
    .bus_wtbt     (bus_wtbt),
    .bus_din      (bus_din),
    .bus_rply     (bus_rply),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One data phase: ack arrives at detection edge + ack_dly; lat is the detection-relative
  // edge at which bus_rply must first be high (-1 = never).
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  wtbt;
    logic [15:0] dout;
    logic [15:0] rdata;
    int          ack_dly;
    bit          req;
    logic [14:0] maddr;
    logic [1:0]  be;
    int          lat;
    logic [15:0] din;
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [15:0] addr, input logic [1:0] wtbt,
                              input logic [15:0] dout, input logic [15:0] rdata, input int ack_dly,
                              input bit req, input logic [14:0] maddr, input logic [1:0] be,
                              input int lat, input logic [15:0] din);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wtbt = wtbt; v.dout = dout; v.rdata = rdata;
    v.ack_dly = ack_dly; v.req = req; v.maddr = maddr; v.be = be; v.lat = lat; v.din = din;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s got=%0h exp=%0h", tag, nm, act, exp);
    end
  endtask

  // Raise the strobe, run the memory side, then drop the strobe after one held reply cycle.
  task automatic phase(input vec_t v, input string tag);
    int got;
    int bad;
    got = -1;
    bad = 0;
    bus_addr = v.addr;
    bus_dout = v.dout;
    bus_wtbt = v.wtbt;
    if (v.wr) bus_dout_stb = 1'b1;
    else      bus_din_stb  = 1'b1;
    tick();
    for (int k = 0; k <= 100; k++) begin
      if (bus_rply && got < 0) got = k;
      if (mem_req !== (v.req && (k < v.ack_dly))) bad++;
      if (mem_req && (mem_addr !== v.maddr || mem_we !== v.wr || mem_be !== v.be ||
                      (v.wr && mem_wdata !== v.dout))) bad++;
      if (got >= 0) break;
      mem_ack   = v.req && (k + 1 == v.ack_dly);
      mem_rdata = mem_ack ? v.rdata : ~v.rdata;
      tick();
    end
    mem_ack = 1'b0;
    check(tag, "req_shape", bad, 0);
    check(tag, "rply_lat", got, v.lat);
    if (got >= 0) begin
      tick();
      check(tag, "rply_hold", {31'd0, bus_rply}, 1);
    end
    bus_din_stb  = 1'b0;
    bus_dout_stb = 1'b0;
    tick();
    check(tag, "rply_clear", {31'd0, bus_rply}, 0);
    check(tag, "bus_din", {16'd0, bus_din}, {16'd0, v.din});
    $display("txn %s wr=%0d addr=%o lat=%0d din=%h", tag, v.wr, v.addr, got, bus_din);
  endtask

  vec_t vt [9];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0; bus_addr = '0; bus_dout = '0; bus_sync = 1'b0; bus_din_stb = 1'b0;
    bus_dout_stb = 1'b0; bus_wtbt = 2'b00; mem_ack = 1'b0; mem_rdata = '0;

    vt[0] = mk(0, 16'o001000, 2'b00, 16'h0000, 16'h1234, 2, 1, 15'o000400, 2'b11, 3, 16'h1234);
    vt[1] = mk(1, 16'o002001, 2'b10, 16'hAB00, 16'h0000, 1, 1, 15'o001000, 2'b10, 3, 16'h1234);
    vt[2] = mk(1, 16'o120000, 2'b11, 16'h5555, 16'h0000, 0, 0, 15'o050000, 2'b11, 3, 16'h1234);
    vt[3] = mk(0, 16'o177560, 2'b00, 16'h0000, 16'h9999, 0, 0, 15'o000000, 2'b11, -1, 16'h1234);
    vt[4] = mk(0, 16'o000002, 2'b00, 16'h0000, 16'hBEEF, 5, 1, 15'o000001, 2'b11, 6, 16'hBEEF);
    vt[5] = mk(1, 16'o000010, 2'b00, 16'h1111, 16'h0000, 1, 1, 15'o000004, 2'b00, 3, 16'hBEEF);
    vt[6] = mk(0, 16'o100000, 2'b00, 16'h0000, 16'h5A5A, 1, 1, 15'o040000, 2'b11, 3, 16'h5A5A);
    vt[7] = mk(1, 16'o177000, 2'b11, 16'h2222, 16'h0000, 0, 0, 15'o000000, 2'b11, -1, 16'h5A5A);
    vt[8] = mk(0, 16'o176776, 2'b00, 16'h0000, 16'h0F0F, 1, 1, 15'o077377, 2'b11, 3, 16'h0F0F);

    repeat (3) tick();
    check("reset", "rply", {31'd0, bus_rply}, 0);
    check("reset", "req", {31'd0, mem_req}, 0);
    check("reset", "outs", {bus_din, mem_wdata}, 32'd0);
    check("reset", "ctl", {14'd0, mem_we, mem_addr, mem_be}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      bus_addr = vt[i].addr;
      bus_sync = 1'b1;
      tick();
      phase(vt[i], $sformatf("vec%0d", i));
      bus_sync = 1'b0;
      tick();
    end

    // Read-modify-write inside one bus_sync.
    bus_addr = 16'o000100; bus_sync = 1'b1;
    tick();
    rv = mk(0, 16'o000100, 2'b00, 16'h0000, 16'h00FF, 1, 1, 15'o000040, 2'b11, 3, 16'h00FF);
    phase(rv, "rmw_rd");
    rv = mk(1, 16'o000100, 2'b11, 16'h0100, 16'h0000, 1, 1, 15'o000040, 2'b11, 3, 16'h00FF);
    phase(rv, "rmw_wr");
    bus_sync = 1'b0;
    tick();

    // Abort before ack: request must be held into DRAIN, data dropped, no reply.
    bus_addr = 16'o000200; bus_sync = 1'b1;
    tick();
    bus_din_stb = 1'b1;
    tick();
    check("abort", "req_start", {31'd0, mem_req}, 1);
    bus_sync = 1'b0; bus_din_stb = 1'b0;
    tick();
    tick();
    check("abort", "req_held", {31'd0, mem_req}, 1);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("abort", "req_drop", {31'd0, mem_req}, 0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus_rply) cnt++;
      tick();
    end
    check("abort", "no_rply", cnt, 0);
    check("abort", "din_kept", {16'd0, bus_din}, {16'd0, 16'h00FF});
    $display("txn abort addr=%o din=%h", 16'o000200, bus_din);
    bus_addr = 16'o000300; bus_sync = 1'b1;
    tick();
    rv = mk(0, 16'o000300, 2'b00, 16'h0000, 16'hC0DE, 1, 1, 15'o000140, 2'b11, 3, 16'hC0DE);
    phase(rv, "post_abort");
    bus_sync = 1'b0;
    tick();

    // Both strobe edges in the same cycle: read wins.
    bus_addr = 16'o000400; bus_dout = 16'h3333; bus_wtbt = 2'b01; bus_sync = 1'b1;
    tick();
    bus_din_stb = 1'b1; bus_dout_stb = 1'b1;
    tick();
    check("dual", "req", {31'd0, mem_req}, 1);
    check("dual", "we_be", {29'd0, mem_we, mem_be}, {29'd0, 1'b0, 2'b11});
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("dual", "rply", {31'd0, bus_rply}, 1);
    check("dual", "din", {16'd0, bus_din}, {16'd0, 16'h7777});
    bus_din_stb = 1'b0; bus_dout_stb = 1'b0; bus_sync = 1'b0;
    tick();
    $display("txn dual addr=%o din=%h", 16'o000400, bus_din);
    tick();

    // bus_sync lost while replying: reply clears on the next clock.
    bus_addr = 16'o000500; bus_sync = 1'b1;
    tick();
    bus_din_stb = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h1357;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("syncdrop", "rply_on", {31'd0, bus_rply}, 1);
    bus_sync = 1'b0;
    tick();
    check("syncdrop", "rply_off", {31'd0, bus_rply}, 0);
    bus_din_stb = 1'b0;
    tick();
    $display("txn syncdrop addr=%o din=%h", 16'o000500, bus_din);

    // Asynchronous reset mid-request.
    bus_addr = 16'o000600; bus_sync = 1'b1;
    tick();
    bus_din_stb = 1'b1;
    tick();
    check("rst_mid", "req_before", {31'd0, mem_req}, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid", "req", {31'd0, mem_req}, 0);
    check("rst_mid", "rply", {31'd0, bus_rply}, 0);
    check("rst_mid", "din", {16'd0, bus_din}, 32'd0);
    check("rst_mid", "ctl", {14'd0, mem_we, mem_addr, mem_be}, 32'd0);
    bus_din_stb = 1'b0; bus_sync = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Asynchronous reset while bus_rply is high.
    bus_addr = 16'o000700; bus_sync = 1'b1;
    tick();
    bus_din_stb = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h2468;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    check("rst_rply", "rply_on", {31'd0, bus_rply}, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_rply", "rply", {31'd0, bus_rply}, 0);
    bus_din_stb = 1'b0; bus_sync = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    $display("txn rst_rply addr=%o din=%h", 16'o000700, bus_din);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
